// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid,
// synchronous flush and a saturating stall counter.
module pipe_skid_stage #(
    parameter int DATA_W  = 64,
    parameter int PC_W    = 64,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = 32
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PC_W-1:0]   out_pc,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t              state_p0;
    logic                in_ready_p0;
    logic [DATA_W-1:0]   skid_data_p1;
    logic [PC_W-1:0]     skid_pc_p1;
    logic                accept;
    logic                retire;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // With the skid disabled, a full stage can still take a beat when the
    // consumer drains it in the same cycle.
    assign in_ready = (SKID_EN != 0) ? in_ready_p0 : (~out_valid | out_ready);
    assign accept   = in_valid & in_ready & ~flush;
    assign retire   = out_valid & out_ready;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_p0     <= EMPTY;
            out_valid    <= 1'b0;
            in_ready_p0  <= 1'b1;
            out_data     <= '0;
            out_pc       <= '0;
            skid_data_p1 <= '0;
            skid_pc_p1   <= '0;
            stall_cnt    <= '0;
        end else begin
            if (out_valid && !out_ready)
                stall_cnt <= sat_inc(stall_cnt);

            // Flush drops held entries but leaves the data registers untouched.
            if (flush) begin
                state_p0    <= EMPTY;
                out_valid   <= 1'b0;
                in_ready_p0 <= 1'b1;
            end else begin
                case (state_p0)
                    EMPTY: begin
                        if (accept) begin
                            state_p0  <= FULL;
                            out_valid <= 1'b1;
                            out_data  <= in_data;
                            out_pc    <= in_pc;
                        end
                    end
                    FULL: begin
                        if (accept && retire) begin
                            out_data <= in_data;
                            out_pc   <= in_pc;
                        end else if (accept && (SKID_EN != 0)) begin
                            state_p0     <= SKID;
                            in_ready_p0  <= 1'b0;
                            skid_data_p1 <= in_data;
                            skid_pc_p1   <= in_pc;
                        end else if (retire) begin
                            state_p0  <= EMPTY;
                            out_valid <= 1'b0;
                        end
                    end
                    SKID: begin
                        if (retire) begin
                            state_p0    <= FULL;
                            in_ready_p0 <= 1'b1;
                            out_data    <= skid_data_p1;
                            out_pc      <= skid_pc_p1;
                        end
                    end
                    default: begin
                        state_p0    <= EMPTY;
                        out_valid   <= 1'b0;
                        in_ready_p0 <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed table, corner sequences and a random
// run against a small FIFO model, on skid, no-skid and 4-bit-counter instances.
module tb_pipe_skid_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic sys_rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Index 0: SKID_EN=1, index 1: SKID_EN=0
    logic [1:0]        iv, ord, fl, ov, ir;
    logic [1:0][15:0]  id, od;
    logic [1:0][31:0]  ipc, opc, st;

    logic        iv4, ord4, fl4, ov4, ir4;
    logic [15:0] id4, od4;
    logic [31:0] ipc4, opc4;
    logic [3:0]  st4;

    pipe_skid_stage #(.DATA_W(16), .PC_W(32), .SKID_EN(1), .CNT_W(32)) u_skid (
        .sys_clk(clk), .sys_rst(sys_rst), .flush(fl[0]),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]), .in_pc(ipc[0]),
        .out_valid(ov[0]), .out_ready(ord[0]), .out_data(od[0]), .out_pc(opc[0]),
        .stall_cnt(st[0]));

    pipe_skid_stage #(.DATA_W(16), .PC_W(32), .SKID_EN(0), .CNT_W(32)) u_noskid (
        .sys_clk(clk), .sys_rst(sys_rst), .flush(fl[1]),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]), .in_pc(ipc[1]),
        .out_valid(ov[1]), .out_ready(ord[1]), .out_data(od[1]), .out_pc(opc[1]),
        .stall_cnt(st[1]));

    pipe_skid_stage #(.DATA_W(16), .PC_W(32), .SKID_EN(1), .CNT_W(4)) u_sat (
        .sys_clk(clk), .sys_rst(sys_rst), .flush(fl4),
        .in_valid(iv4), .in_ready(ir4), .in_data(id4), .in_pc(ipc4),
        .out_valid(ov4), .out_ready(ord4), .out_data(od4), .out_pc(opc4),
        .stall_cnt(st4));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        iv = '0; ord = '0; fl = '0; id = '0; ipc = '0;
        iv4 = 1'b0; ord4 = 1'b0; fl4 = 1'b0; id4 = '0; ipc4 = '0;
        sys_rst = 1'b1;
        @(negedge clk);
        #2 sys_rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        iv, ord, fl;
        logic [15:0] d;
        logic [31:0] pc;
        logic        ev, eir;
        logic [15:0] ed;
        logic [31:0] epc;
        logic [31:0] est;
    } vec_t;

    vec_t tbl [14];

    // Reference model: held beats as a small FIFO, {pc,data} per entry
    int          mcnt  [2];
    logic [47:0] mf    [2][2];
    logic [47:0] mlast [2];
    logic [31:0] mst   [2];

    initial begin
        // Backpressure with A/B/C, then flush while in the skid state
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h11, 32'h80000000, 1'b0, 1'b1, 16'h00, 32'h00000000, 32'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 16'h22, 32'h80000004, 1'b1, 1'b1, 16'h11, 32'h80000000, 32'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 16'h33, 32'h80000008, 1'b1, 1'b0, 16'h11, 32'h80000000, 32'd1};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 16'h33, 32'h80000008, 1'b1, 1'b0, 16'h11, 32'h80000000, 32'd2};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 16'h33, 32'h80000008, 1'b1, 1'b0, 16'h11, 32'h80000000, 32'd3};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 16'h33, 32'h80000008, 1'b1, 1'b1, 16'h22, 32'h80000004, 32'd3};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 16'h00, 32'h00000000, 1'b1, 1'b1, 16'h33, 32'h80000008, 32'd3};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 16'h00, 32'h00000000, 1'b0, 1'b1, 16'h33, 32'h80000008, 32'd3};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 16'h55, 32'h8000000C, 1'b0, 1'b1, 16'h33, 32'h80000008, 32'd3};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 16'h66, 32'h80000010, 1'b1, 1'b1, 16'h55, 32'h8000000C, 32'd3};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 16'h44, 32'h80000014, 1'b1, 1'b0, 16'h55, 32'h8000000C, 32'd4};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 16'h00, 32'h00000000, 1'b0, 1'b1, 16'h55, 32'h8000000C, 32'd5};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 16'h77, 32'h80000018, 1'b0, 1'b1, 16'h55, 32'h8000000C, 32'd5};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 16'h00, 32'h00000000, 1'b0, 1'b1, 16'h55, 32'h8000000C, 32'd5};

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst.out_valid", 64'(ov[0]), 64'd0);
        chk("rst.in_ready",  64'(ir[0]), 64'd1);
        chk("rst.out_data",  64'(od[0]), 64'd0);
        chk("rst.out_pc",    64'(opc[0]), 64'd0);
        chk("rst.stall_cnt", 64'(st[0]), 64'd0);
        @(posedge clk);
        #1;

        // Directed table
        for (int i = 0; i < 14; i++) begin
            iv[0] = tbl[i].iv; ord[0] = tbl[i].ord; fl[0] = tbl[i].fl;
            id[0] = tbl[i].d;  ipc[0] = tbl[i].pc;
            @(negedge clk);
            chk($sformatf("tbl%0d.out_valid", i), 64'(ov[0]), 64'(tbl[i].ev));
            chk($sformatf("tbl%0d.in_ready", i),  64'(ir[0]), 64'(tbl[i].eir));
            chk($sformatf("tbl%0d.out_data", i),  64'(od[0]), 64'(tbl[i].ed));
            chk($sformatf("tbl%0d.out_pc", i),    64'(opc[0]), 64'(tbl[i].epc));
            chk($sformatf("tbl%0d.stall_cnt", i), 64'(st[0]), 64'(tbl[i].est));
            @(posedge clk);
            #1;
        end

        // Streaming with out_ready held high
        do_reset();
        for (int i = 0; i < 4; i++) begin
            iv[0] = (i < 3); ord[0] = 1'b1;
            ipc[0] = 32'h80000000 + 32'(4 * i); id[0] = 16'(i);
            @(negedge clk);
            chk($sformatf("stream%0d.in_ready", i), 64'(ir[0]), 64'd1);
            if (i > 0) begin
                chk($sformatf("stream%0d.out_valid", i), 64'(ov[0]), 64'd1);
                chk($sformatf("stream%0d.out_pc", i), 64'(opc[0]), 64'(32'h80000000 + 32'(4 * (i - 1))));
            end
            @(posedge clk);
            #1;
        end
        chk("stream.stall_cnt", 64'(st[0]), 64'd0);

        // No-skid: combinational in_ready follows out_ready
        do_reset();
        iv[1] = 1'b1; ord[1] = 1'b0; id[1] = 16'hA1; ipc[1] = 32'h100;
        #1 chk("noskid.empty_in_ready", 64'(ir[1]), 64'd1);
        @(posedge clk);
        #1;
        id[1] = 16'hB2; ipc[1] = 32'h104;
        #1;
        chk("noskid.full_out_valid", 64'(ov[1]), 64'd1);
        chk("noskid.full_in_ready",  64'(ir[1]), 64'd0);
        chk("noskid.full_out_data",  64'(od[1]), 64'hA1);
        ord[1] = 1'b1;
        #1 chk("noskid.drain_in_ready", 64'(ir[1]), 64'd1);
        @(posedge clk);
        #1;
        iv[1] = 1'b0; ord[1] = 1'b0;
        #1;
        chk("noskid.replace_out_data", 64'(od[1]), 64'hB2);
        chk("noskid.replace_out_pc",   64'(opc[1]), 64'h104);
        chk("noskid.replace_out_valid", 64'(ov[1]), 64'd1);

        // Saturating 4-bit counter
        do_reset();
        iv4 = 1'b1; ord4 = 1'b0; id4 = 16'h5A; ipc4 = 32'h200;
        repeat (10) @(posedge clk);
        #1 chk("sat.stall_cnt_mid", 64'(st4), 64'd9);
        repeat (10) @(posedge clk);
        #1;
        chk("sat.stall_cnt_max", 64'(st4), 64'd15);
        chk("sat.out_valid", 64'(ov4), 64'd1);
        chk("sat.in_ready", 64'(ir4), 64'd0);

        // Asynchronous reset while in the skid state
        do_reset();
        iv[0] = 1'b1; ord[0] = 1'b0; id[0] = 16'hC1; ipc[0] = 32'h300;
        @(posedge clk);
        #1 id[0] = 16'hC2;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        chk("arst.pre_in_ready", 64'(ir[0]), 64'd0);
        chk("arst.pre_stall_cnt", 64'(st[0]), 64'd1);
        #2 sys_rst = 1'b1;
        #1;
        chk("arst.out_valid", 64'(ov[0]), 64'd0);
        chk("arst.in_ready",  64'(ir[0]), 64'd1);
        chk("arst.stall_cnt", 64'(st[0]), 64'd0);
        chk("arst.out_data",  64'(od[0]), 64'd0);
        @(negedge clk);
        #2 sys_rst = 1'b0;
        @(posedge clk);
        #1;

        // Random run against the FIFO model, both skid variants
        do_reset();
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0; mlast[k] = '0; mst[k] = '0; mf[k][0] = '0; mf[k][1] = '0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int k = 0; k < 2; k++) begin
                iv[k]  = ($urandom_range(0, 9) < 7);
                ord[k] = ($urandom_range(0, 9) < 6);
                fl[k]  = ($urandom_range(0, 19) == 0);
                id[k]  = 16'($urandom);
                ipc[k] = $urandom;
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                logic mir, mov, acc, ret;
                mov = (mcnt[k] > 0);
                mir = (k == 0) ? (mcnt[k] < 2) : (mcnt[k] == 0 || ord[k]);
                chk($sformatf("rnd%0d.k%0d.out_valid", cyc, k), 64'(ov[k]), 64'(mov));
                chk($sformatf("rnd%0d.k%0d.in_ready", cyc, k),  64'(ir[k]), 64'(mir));
                chk($sformatf("rnd%0d.k%0d.out_data", cyc, k),  64'(od[k]), 64'(mlast[k][15:0]));
                chk($sformatf("rnd%0d.k%0d.out_pc", cyc, k),    64'(opc[k]), 64'(mlast[k][47:16]));
                chk($sformatf("rnd%0d.k%0d.stall_cnt", cyc, k), 64'(st[k]), 64'(mst[k]));
                acc = iv[k] && mir && !fl[k];
                ret = mov && ord[k];
                if (mov && !ord[k] && mst[k] != 32'hFFFFFFFF)
                    mst[k] = mst[k] + 32'd1;
                if (fl[k]) begin
                    mcnt[k] = 0;
                end else begin
                    if (ret) begin
                        mf[k][0] = mf[k][1];
                        mcnt[k]  = mcnt[k] - 1;
                    end
                    if (acc) begin
                        mf[k][mcnt[k]] = {ipc[k], id[k]};
                        mcnt[k] = mcnt[k] + 1;
                    end
                end
                if (mcnt[k] > 0)
                    mlast[k] = mf[k][0];
            end
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
